l_stf_seq: RTL and testbench

Sequencer that plays the 802.11 legacy short training field (L-STF) out of the 16-entry L-STF sample ROM. On a start pulse it walks the ROM address NUM_REP times, 16 samples per repetition. It emits the I/Q words on a valid/ready stream toward the preamble/data mux of the TX chain and signals completion. The ROM stays external and combinational; this block owns addressing, repetition count, flow control and optional edge windowing.

---
 rtl/l_stf_seq_pkg.sv | 20 ++
 rtl/l_stf_seq_iq_halve.sv | 21 ++
 rtl/l_stf_seq.sv | 111 +++++++++++
 tb/tb_l_stf_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/l_stf_seq_pkg.sv
// Shared types and constants for the L-STF sequencer.
package l_stf_seq_pkg;

  localparam int unsigned STF_PERIOD = 16;
  localparam int unsigned IQ_W       = 16;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Total number of samples in one L-STF for a given repetition count.
  function automatic logic [CNT_W-1:0] total_len(input int unsigned num_rep);
    return CNT_W'(STF_PERIOD * num_rep);
  endfunction

endpackage

// File: rtl/l_stf_seq_iq_halve.sv
// stf_iq_halve: per-component arithmetic halving of a packed {I,Q} word.
// Only built when L_STF_SEQ_WINDOW_EN is defined (the sole user is the windowing path).
`ifdef L_STF_SEQ_WINDOW_EN
module stf_iq_halve
  import l_stf_seq_pkg::*;
(
  input  logic [2*IQ_W-1:0] iq_in,
  output logic [2*IQ_W-1:0] iq_out
);

  logic signed [IQ_W-1:0] i_s;
  logic signed [IQ_W-1:0] q_s;

  always_comb begin
    i_s    = iq_in[2*IQ_W-1:IQ_W];
    q_s    = iq_in[IQ_W-1:0];
    iq_out = {i_s >>> 1, q_s >>> 1};
  end

endmodule
`endif

// File: rtl/l_stf_seq.sv
// l_stf_seq: plays the L-STF out of an external 16-entry ROM as a valid/ready stream.
// Define L_STF_SEQ_WINDOW_EN to halve the first and last samples (edge windowing).
module l_stf_seq
  import l_stf_seq_pkg::*;
#(
  parameter int unsigned NUM_REP = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2*IQ_W-1:0] rom_dout,
  output logic [2*IQ_W-1:0] out_iq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] TOTAL    = total_len(NUM_REP);
  localparam logic [CNT_W-1:0] LAST_IDX = TOTAL - CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               accept_last;
  logic               load;
  logic [2*IQ_W-1:0]  sample;

  // cnt reaching TOTAL marks that the final sample is already in the output register.
  always_comb begin
    accept      = out_valid && out_ready;
    accept_last = accept && out_last;
    load        = (state == RUN) && (cnt != TOTAL) && (!out_valid || out_ready);
  end

`ifdef L_STF_SEQ_WINDOW_EN
  logic [2*IQ_W-1:0] iq_half;
  logic              edge_sample;

  stf_iq_halve u_halve (
    .iq_in  (rom_dout),
    .iq_out (iq_half)
  );

  always_comb begin
    edge_sample = (cnt == '0) || (cnt == LAST_IDX);
    sample      = edge_sample ? iq_half : rom_dout;
  end
`else
  always_comb begin
    sample = rom_dout;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      rom_addr  <= '0;
      out_iq    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (abort) begin
        cnt       <= '0;
        rom_addr  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (state == IDLE && start) begin
          cnt      <= '0;
          rom_addr <= '0;
        end
        if (load) begin
          out_iq    <= sample;
          out_valid <= 1'b1;
          out_last  <= (cnt == LAST_IDX);
          cnt       <= cnt + 1'b1;
          rom_addr  <= cnt[ADDR_W-1:0] + ADDR_W'(1);
        end else if (accept) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_l_stf_seq.sv
// Self-checking bench for l_stf_seq (NUM_REP=10) with a behavioural L-STF ROM.
module tb_l_stf_seq;

  localparam logic [31:0] ROM [0:15] = '{
    32'h02f202f2, 32'hf78a000d, 32'h042a0000, 32'hff2f09a6,
    32'h05e8fe7e, 32'hff2f09b0, 32'h0000fbd6, 32'hf78e0011,
    32'h02f102f3, 32'h000df78a, 32'hfbd60000, 32'h09a6ff2f,
    32'hfe7e05e8, 32'h09b0ff2e, 32'hfbd5ffff, 32'h019803d9
  };

`ifdef L_STF_SEQ_WINDOW_EN
  localparam logic [31:0] S0_EXP   = 32'h01790179;
  localparam logic [31:0] S159_EXP = 32'h00cc01ec;
`else
  localparam logic [31:0] S0_EXP   = 32'h02f202f2;
  localparam logic [31:0] S159_EXP = 32'h019803d9;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [3:0]  rom_addr;
  logic [31:0] rom_dout;
  logic [31:0] out_iq;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rom_dout = ROM[rom_addr];

  l_stf_seq #(.NUM_REP(10)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_iq    (out_iq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [31:0] exp_iq(input int k);
    logic [31:0] w;
    w = ROM[4'(k % 16)];
`ifdef L_STF_SEQ_WINDOW_EN
    if (k == 0 || k == 159) begin
      logic signed [15:0] i_s;
      logic signed [15:0] q_s;
      i_s = w[31:16];
      q_s = w[15:0];
      i_s = i_s >>> 1;
      q_s = q_s >>> 1;
      w   = {i_s, q_s};
    end
`endif
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic st, ab, rdy;
    logic ev, el, eb, ed;
    logic [3:0] ea;
    int ek;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int k, stalls, cyc, dones, done_cyc;
    logic prev_stall, rdy;
    logic [31:0] prev_iq;
    logic prev_last;

    //              st ab rdy ev el eb ed addr  sample
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, -1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2,  1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3,  2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4,  3};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, -1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst iq",    out_iq,           32'h0);
    chk("rst valid", 32'(out_valid),   32'h0);
    chk("rst last",  32'(out_last),    32'h0);
    chk("rst busy",  32'(busy),        32'h0);
    chk("rst done",  32'(done),        32'h0);
    chk("rst addr",  32'(rom_addr),    32'h0);
    @(negedge clk) rstn = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d last", i),  32'(out_last),  32'(tbl[i].el));
      chk($sformatf("tbl%0d busy", i),  32'(busy),      32'(tbl[i].eb));
      chk($sformatf("tbl%0d done", i),  32'(done),      32'(tbl[i].ed));
      chk($sformatf("tbl%0d addr", i),  32'(rom_addr),  32'(tbl[i].ea));
      if (tbl[i].ek >= 0) chk($sformatf("tbl%0d iq", i), out_iq, exp_iq(tbl[i].ek));
    end
    start = 1'b0; abort = 1'b0;

    // Full run, continuous ready: cycle c is T+c with start sampled at T.
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 163; c++) begin
      chk($sformatf("run c%0d valid", c), 32'(out_valid), 32'(c >= 2 && c <= 161));
      chk($sformatf("run c%0d busy", c),  32'(busy),      32'(c >= 1 && c <= 162));
      chk($sformatf("run c%0d done", c),  32'(done),      32'(c == 162));
      if (c >= 2 && c <= 161) begin
        chk($sformatf("run c%0d iq", c),   out_iq,         exp_iq(c - 2));
        chk($sformatf("run c%0d last", c), 32'(out_last),  32'(c == 161));
      end
      if (c == 2)   chk("sample0",   out_iq, S0_EXP);
      if (c == 4)   chk("sample2",   out_iq, 32'h042a0000);
      if (c == 8)   chk("sample6",   out_iq, 32'h0000fbd6);
      if (c == 18)  chk("sample16",  out_iq, 32'h02f202f2);
      if (c == 161) chk("sample159", out_iq, S159_EXP);
      step();
    end

    // Random backpressure with spurious start pulses while running.
    k = 0; stalls = 0; cyc = 0; dones = 0; done_cyc = -1;
    prev_stall = 1'b0; prev_iq = '0; prev_last = 1'b0;
    out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (dones == 0 && cyc < 2000) begin
      if (prev_stall) begin
        chk($sformatf("stall c%0d valid", cyc), 32'(out_valid), 32'h1);
        chk($sformatf("stall c%0d iq", cyc),    out_iq,         prev_iq);
        chk($sformatf("stall c%0d last", cyc),  32'(out_last),  32'(prev_last));
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("bp samples at done", 32'(k), 32'd160);
      end
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      start = busy && ($urandom_range(0, 3) == 0);
      if (out_valid) begin
        if (rdy) begin
          chk($sformatf("bp s%0d iq", k),   out_iq,        exp_iq(k));
          chk($sformatf("bp s%0d last", k), 32'(out_last), 32'(k == 159));
          k++;
        end else begin
          stalls++;
        end
      end
      prev_stall = out_valid && !rdy;
      prev_iq    = out_iq;
      prev_last  = out_last;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("bp one done", 32'(dones), 32'd1);
    chk("bp total cycles", 32'(done_cyc), 32'(161 + stalls));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp post%0d done", i), 32'(done), 32'h0);
      chk($sformatf("bp post%0d busy", i), 32'(busy), 32'h0);
      step();
    end

    // Abort at sample 50 together with start.
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 51; i++) step();
    chk("ab s50 iq", out_iq, exp_iq(50));
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("ab valid", 32'(out_valid), 32'h0);
    chk("ab last",  32'(out_last),  32'h0);
    chk("ab busy",  32'(busy),      32'h0);
    chk("ab addr",  32'(rom_addr),  32'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ab post%0d done", i),  32'(done),      32'h0);
      chk($sformatf("ab post%0d valid", i), 32'(out_valid), 32'h0);
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ab restart valid", 32'(out_valid), 32'h1);
    chk("ab restart iq",    out_iq,         exp_iq(0));

    // Asynchronous reset at sample 40.
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 41; i++) step();
    chk("rr s40 iq", out_iq, exp_iq(40));
    rstn = 1'b0;
    #1;
    chk("rr iq",    out_iq,         32'h0);
    chk("rr valid", 32'(out_valid), 32'h0);
    chk("rr last",  32'(out_last),  32'h0);
    chk("rr busy",  32'(busy),      32'h0);
    chk("rr done",  32'(done),      32'h0);
    chk("rr addr",  32'(rom_addr),  32'h0);
    @(negedge clk) rstn = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rr restart iq", out_iq, S0_EXP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
